// File: rtl/regfile_scoreboard.sv
// Integer register file with optional zero register and writeback bypass,
// plus per-register pending-write counters for RAW hazard detection at issue.
module regfile_scoreboard #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int CNT_W    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     rs1_addr,
  input  logic [AW-1:0]     rs2_addr,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  output logic              rs1_busy,
  output logic              rs2_busy,
  input  logic              issue_en,
  input  logic [AW-1:0]     issue_rd,
  output logic              issue_ready,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  output logic [2**AW-1:0]  busy_vec,
  output logic              err_underflow
);

  localparam int NREGS = 2 ** AW;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [XLEN-1:0]  regs_r [NREGS];
  logic [CNT_W-1:0] cnt_r  [NREGS];
  logic             err_r;
  logic             issue_ready_s;

  function automatic logic writable(input logic [AW-1:0] a);
    return !((ZERO_REG != 0) && (a == {AW{1'b0}}));
  endfunction

  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] a,
                                                input logic [XLEN-1:0] stored,
                                                input logic w_en, input logic [AW-1:0] w_addr,
                                                input logic [XLEN-1:0] w_data);
    if (!writable(a)) return {XLEN{1'b0}};
    else if ((BYPASS != 0) && w_en && (w_addr == a)) return w_data;
    else return stored;
  endfunction

  // A retiring write to the last pending producer clears the hazard in the same cycle.
  function automatic logic busy_port(input logic [AW-1:0] a, input logic [CNT_W-1:0] cnt,
                                     input logic w_en, input logic [AW-1:0] w_addr);
    if (!writable(a)) return 1'b0;
    else if ((BYPASS != 0) && w_en && (w_addr == a) && (cnt != CNT_ZERO)) return cnt != CNT_ONE;
    else return cnt != CNT_ZERO;
  endfunction

  // Read ports and hazard flags.
  always_comb begin
    rs1_data = read_port(rs1_addr, regs_r[rs1_addr], wb_en, wb_addr, wb_data);
    rs2_data = read_port(rs2_addr, regs_r[rs2_addr], wb_en, wb_addr, wb_data);
    rs1_busy = busy_port(rs1_addr, cnt_r[rs1_addr], wb_en, wb_addr);
    rs2_busy = busy_port(rs2_addr, cnt_r[rs2_addr], wb_en, wb_addr);
  end

  // Issue stalls only when the destination counter is saturated.
  always_comb begin
    if (!writable(issue_rd)) issue_ready_s = 1'b1;
    else if (flush) issue_ready_s = 1'b1;
    else if (cnt_r[issue_rd] != CNT_MAX) issue_ready_s = 1'b1;
    else issue_ready_s = 1'b0;
  end

  // Busy vector mirrors counter state.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      busy_vec[i] = cnt_r[i] != CNT_ZERO;
    end
  end

  assign issue_ready   = issue_ready_s;
  assign err_underflow = err_r;

  // Register array storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs_r[i] <= {XLEN{1'b0}};
    end else if (wb_en && writable(wb_addr)) begin
      regs_r[wb_addr] <= wb_data;
    end
  end

  // Pending-write counters; flush overrides both increment and decrement.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) cnt_r[i] <= CNT_ZERO;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        logic inc_s, dec_s;
        inc_s = issue_en && issue_ready_s && (issue_rd == AW'(i)) && writable(AW'(i)) && !flush;
        dec_s = wb_en && (wb_addr == AW'(i)) && writable(AW'(i)) && (cnt_r[i] != CNT_ZERO);
        if (flush) cnt_r[i] <= CNT_ZERO;
        else if (inc_s && !dec_s) cnt_r[i] <= cnt_r[i] + CNT_ONE;
        else if (dec_s && !inc_s) cnt_r[i] <= cnt_r[i] - CNT_ONE;
        else cnt_r[i] <= cnt_r[i];
      end
    end
  end

  // Sticky flag for a writeback with no pending producer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_r <= 1'b0;
    end else if (wb_en && writable(wb_addr) && (cnt_r[wb_addr] == CNT_ZERO) && !flush) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised integer register file for the in-order RISC-V pipeline, generalised in data width and depth.
- Adds an optional hard-wired zero register and optional write-to-read bypass.
- Adds a per-register pending-write scoreboard: counters track in-flight producers so decode can detect RAW hazards and stall issue.
- Sits between decode (issue/read) and writeback (write/retire).

Parameters:
- XLEN, 32, data width of each register.
- AW, 5, address width; NREGS = 2**AW registers.
- CNT_W, 2, width of each pending-write counter; max outstanding writes per register = 2**CNT_W - 1.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never marked busy.
- BYPASS, 1, 1 = same-cycle writeback data forwarded to read ports.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- rs1_addr  input  AW  read port 1 address.
- rs2_addr  input  AW  read port 2 address.
- rs1_data  output  XLEN  read port 1 data, combinational.
- rs2_data  output  XLEN  read port 2 data, combinational.
- rs1_busy  output  1  register at rs1_addr has a pending write.
- rs2_busy  output  1  register at rs2_addr has a pending write.
- issue_en  input  1  decode issues an instruction writing issue_rd.
- issue_rd  input  AW  destination of the issued instruction.
- issue_ready  output  1  issue accepted this cycle if issue_en=1.
- wb_en  input  1  writeback valid.
- wb_addr  input  AW  writeback destination.
- wb_data  input  XLEN  writeback data.
- flush  input  1  synchronous clear of all pending counters (pipeline squash).
- busy_vec  output  NREGS  bit i = counter i nonzero (registered state).
- err_underflow  output  1  sticky: writeback retired to a register with zero pending count.

Behaviour:
- Reset (rst=0, async): all registers = 0, all counters = 0, err_underflow = 0.
  - Resulting outputs: busy_vec = 0, rs*_busy = 0, issue_ready = 1.
- Writability: an address is writable unless ZERO_REG=1 and the address is 0.
- Write:
  - At posedge, if wb_en and wb_addr is writable, REG[wb_addr] <= wb_data.
  - flush does not block writes.
- Read:
  - rsN_data = 0 if ZERO_REG=1 and addr = 0.
  - Otherwise, if BYPASS=1, wb_en and wb_addr = addr, rsN_data = wb_data.
  - Otherwise rsN_data = REG[addr].
- Latency: write visible on the read ports the next cycle (same cycle with BYPASS=1).
- issue_ready:
  - 1 when issue_rd is not writable (x0 with ZERO_REG=1), when flush=1, or when cnt[issue_rd] < max.
  - 0 when cnt[issue_rd] = max; the issue is stalled and the counter is unchanged.
  - Depends only on registered state and flush, never on issue_en.
- Counter update at posedge, for each register i:
  - inc = issue_en & issue_ready & issue_rd = i & i writable & !flush.
  - dec = wb_en & wb_addr = i & i writable & cnt[i] != 0.
  - flush=1: cnt[i] <= 0 for all i, overriding inc and dec.
  - Otherwise inc & dec: unchanged; inc only: +1; dec only: -1.
- Underflow: wb_en to a writable address with cnt = 0 and flush=0.
  - Data is still written, the counter stays 0, and err_underflow is set.
  - err_underflow clears only on reset.
- rsN_busy:
  - BYPASS=1: busy = (cnt[addr] - hit) != 0, where hit = wb_en & wb_addr = addr & cnt[addr] != 0. This lets the last pending write retiring this cycle clear the hazard.
  - BYPASS=0: busy = cnt[addr] != 0.
  - Always 0 for a non-writable address.
- Reset asserted mid-operation clears data and counters immediately and asynchronously; in-flight writes are lost.

Test Plan:
- Reset, then read x0..x31 -> all data 0; busy_vec = 0; issue_ready = 1; err_underflow = 0.
- Write x5 = 0xDEADBEEF with rs1_addr = 5, same cycle -> rs1_data = 0xDEADBEEF that cycle (BYPASS=1), and it persists next cycle; write x0 = 0x1234 -> rs1_data(0) = 0 and busy_vec[0] = 0.
- Issue rd = 7 three times (CNT_W=2) -> busy_vec[7] = 1, then issue_ready = 0 on a 4th issue to 7 with the counter held at 3; one wb to 7 -> cnt 2, issue_ready = 1.
- Issue rd = 9 and wb to 9 in the same cycle with cnt = 1 -> cnt stays 1; next cycle wb to 9 with rs2_addr = 9 -> rs2_busy = 0 that cycle, busy_vec[9] = 0 after.
- Set cnt[3] = 2 and cnt[4] = 1, then flush together with issue to 3 -> all counters 0 and busy_vec = 0; then wb to 3 -> data written and err_underflow = 1, sticky until reset.
- Assert rst mid-cycle after writing x10 = 0xA5A5A5A5 with cnt[10] = 1 -> rs1_data(10) = 0 and busy_vec = 0 immediately, without waiting for a clock edge.
